// File: rtl/interval_timer_pkg.sv
// rtl/interval_timer_pkg.sv - shared interval/program encodings and default seconds
package interval_timer_pkg;

  localparam logic [1:0] INT_BASE = 2'b00;
  localparam logic [1:0] INT_EXT  = 2'b01;
  localparam logic [1:0] INT_YEL  = 2'b10;

  localparam logic [1:0] SEL_BASE = 2'b00;
  localparam logic [1:0] SEL_EXT  = 2'b01;
  localparam logic [1:0] SEL_YEL  = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  localparam logic [3:0] DEF_BASE_S = 4'd6;
  localparam logic [3:0] DEF_EXT_S  = 4'd3;
  localparam logic [3:0] DEF_YEL_S  = 4'd2;

  // Encoding 11 aliases to base so the FSM never selects an undefined interval.
  function automatic logic [3:0] pick_interval(input logic [1:0] sel,
                                               input logic [3:0] base,
                                               input logic [3:0] ext,
                                               input logic [3:0] yel);
    case (sel)
      INT_EXT: return ext;
      INT_YEL: return yel;
      default: return base;
    endcase
  endfunction

endpackage

// File: rtl/interval_timer_one_hz_enable.sv
// rtl/interval_timer_one_hz_enable.sv - divides clk to a one-cycle 1 Hz enable
module one_hz_enable #(
  parameter int CLK_DIV = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int             W    = $clog2(CLK_DIV);
  localparam logic [W-1:0]   LAST = W'(CLK_DIV - 1);

  logic [W-1:0] div_q, div_d;

  assign tick = (div_q == LAST);

  // Clearing on load makes the first second after a restart a full period.
  always_comb begin
    div_d = div_q + W'(1);
    if (clear || tick) div_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) div_q <= '0;
    else        div_q <= div_d;
  end

endmodule

// File: rtl/interval_timer.sv
// rtl/interval_timer.sv - programmable seconds countdown feeding the traffic-light FSM
module interval_timer
  import interval_timer_pkg::*;
#(
  parameter int         CLK_DIV  = 100000000,
  parameter logic [3:0] DEF_BASE = DEF_BASE_S,
  parameter logic [3:0] DEF_EXT  = DEF_EXT_S,
  parameter logic [3:0] DEF_YEL  = DEF_YEL_S
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       st_time,
  input  logic [1:0] intervel,
  input  logic       prog_sync,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  output logic       exp,
  output logic [3:0] sec_left,
  output logic       tick_1hz
);

  logic [3:0] base_q, base_d;
  logic [3:0] ext_q, ext_d;
  logic [3:0] yel_q, yel_d;
  logic [3:0] count_q, count_d;
  logic       exp_q, exp_d;
  logic       tick;

  one_hz_enable #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .reset(reset),
    .clear(!st_time),
    .tick (tick)
  );

  // A zero write restores the default, so a loaded interval is never zero.
  always_comb begin
    base_d = base_q;
    ext_d  = ext_q;
    yel_d  = yel_q;
    if (prog_sync) begin
      case (time_param_sel)
        SEL_BASE: base_d = (time_value == 4'd0) ? DEF_BASE : time_value;
        SEL_EXT:  ext_d  = (time_value == 4'd0) ? DEF_EXT  : time_value;
        SEL_YEL:  yel_d  = (time_value == 4'd0) ? DEF_YEL  : time_value;
        default: ;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    exp_d   = 1'b0;
    if (!st_time) begin
      count_d = pick_interval(intervel, base_q, ext_q, yel_q);
    end else if (tick && count_q != 4'd0) begin
      count_d = count_q - 4'd1;
      exp_d   = (count_q == 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      base_q  <= DEF_BASE;
      ext_q   <= DEF_EXT;
      yel_q   <= DEF_YEL;
      count_q <= 4'd0;
      exp_q   <= 1'b0;
    end else begin
      base_q  <= base_d;
      ext_q   <= ext_d;
      yel_q   <= yel_d;
      count_q <= count_d;
      exp_q   <= exp_d;
    end
  end

  assign exp      = exp_q;
  assign sec_left = count_q;
  assign tick_1hz = tick;

endmodule
